// File: rtl/pds_pkg.sv
// Shared types and constants for the PDS bus target port.
package pds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DSWAIT = 3'd1,
    ST_LATCH  = 3'd2,
    ST_REQ    = 3'd3,
    ST_ACK    = 3'd4,
    ST_ERR    = 3'd5,
    ST_HOLD   = 3'd6
  } pds_state_e;

  localparam int TIMEOUT_DEFAULT = 64;

  // PDS strobes and terminations are active-low open-bus style signals.
  localparam logic BUS_RELEASED = 1'b1;
  localparam logic BUS_ASSERTED = 1'b0;

endpackage

// File: rtl/pds_target_if.sv
// PDS bus pins plus the internal register-port handshake seen by pds_target.
interface pds_target_if;

  logic nAS;
  logic RnW;
  logic nLDS;
  logic nUDS;
  logic SEL;
  logic nDTACK;
  logic nBERR;
  logic nDoutOE;
  logic DinLE;
  logic REGREQ;
  logic REGRW;
  logic REGLDS;
  logic REGUDS;
  logic REGACK;

  modport master (
    output nAS, RnW, nLDS, nUDS, SEL, REGACK,
    input  nDTACK, nBERR, nDoutOE, DinLE, REGREQ, REGRW, REGLDS, REGUDS
  );

  modport slave (
    input  nAS, RnW, nLDS, nUDS, SEL, REGACK,
    output nDTACK, nBERR, nDoutOE, DinLE, REGREQ, REGRW, REGLDS, REGUDS
  );

endinterface

// File: rtl/pds_sync.sv
// Two-flop synchronizer; asynchronous clear forces the inactive level.
module pds_sync #(
  parameter int             W    = 1,
  parameter logic [W-1:0]   INIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pds_target.sv
// PDS bus target: claims 68000-style cycles, hands them to the register port,
// and terminates with nDTACK or, on register-port timeout, nBERR.
//
// state  | meaning
// IDLE   | bus idle, waiting for a synchronized nAS
// DSWAIT | write claimed, waiting for a data strobe
// LATCH  | one-cycle write-data latch pulse
// REQ    | register request outstanding, timeout running
// ACK    | nDTACK driven until nAS negates
// ERR    | nBERR driven until nAS negates
// HOLD   | cycle not for this card, wait for nAS to negate
module pds_target
  import pds_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int TOW     = 7
) (
  input  logic C16M,
  input  logic nRES,
  pds_target_if.slave bus
);

  logic [2:0]     sync_q;
  logic           as_n;
  logic           lds_n;
  logic           uds_n;
  pds_state_e     state;
  pds_state_e     state_nx;
  logic [TOW-1:0] cnt;
  logic [TOW-1:0] cnt_nx;
  logic           timeout;
  logic           rw_q, rw_nx;
  logic           lds_q, lds_nx;
  logic           uds_q, uds_nx;
  logic           dtack_q, berr_q, doe_q, dinle_q, req_q;

  pds_sync #(.W(3), .INIT(3'b111)) u_sync (
    .clk   (C16M),
    .rst_n (nRES),
    .d     ({bus.nAS, bus.nLDS, bus.nUDS}),
    .q     (sync_q)
  );

  assign {as_n, lds_n, uds_n} = sync_q;
  assign timeout = (cnt == TOW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rw_nx    = rw_q;
    lds_nx   = lds_q;
    uds_nx   = uds_q;
    unique case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (as_n == BUS_ASSERTED) begin
          if (!bus.SEL) begin
            state_nx = ST_HOLD;
          end else if (bus.RnW) begin
            state_nx = ST_REQ;
            rw_nx    = 1'b1;
            lds_nx   = (lds_n == BUS_ASSERTED);
            uds_nx   = (uds_n == BUS_ASSERTED);
          end else begin
            state_nx = ST_DSWAIT;
          end
        end
      end
      ST_DSWAIT: begin
        if (as_n == BUS_RELEASED) begin
          state_nx = ST_IDLE;
        end else if (timeout) begin
          state_nx = ST_ERR;
        end else begin
          cnt_nx = cnt + TOW'(1);
          if ((lds_n == BUS_ASSERTED) || (uds_n == BUS_ASSERTED)) begin
            state_nx = ST_LATCH;
            rw_nx    = 1'b0;
            lds_nx   = (lds_n == BUS_ASSERTED);
            uds_nx   = (uds_n == BUS_ASSERTED);
          end
        end
      end
      ST_LATCH: begin
        if (as_n == BUS_RELEASED) begin
          state_nx = ST_IDLE;
        end else if (timeout) begin
          state_nx = ST_ERR;
        end else begin
          cnt_nx   = cnt + TOW'(1);
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        // master abort outranks a same-cycle acknowledge; ack outranks timeout
        if (as_n == BUS_RELEASED) begin
          state_nx = ST_IDLE;
        end else if (bus.REGACK) begin
          state_nx = ST_ACK;
        end else if (timeout) begin
          state_nx = ST_ERR;
        end else begin
          cnt_nx = cnt + TOW'(1);
        end
      end
      ST_ACK, ST_ERR, ST_HOLD: begin
        if (as_n == BUS_RELEASED) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the pins never glitch.
  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rw_q    <= 1'b1;
      lds_q   <= 1'b0;
      uds_q   <= 1'b0;
      dtack_q <= BUS_RELEASED;
      berr_q  <= BUS_RELEASED;
      doe_q   <= BUS_RELEASED;
      dinle_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rw_q    <= rw_nx;
      lds_q   <= lds_nx;
      uds_q   <= uds_nx;
      dtack_q <= (state_nx == ST_ACK) ? BUS_ASSERTED : BUS_RELEASED;
      berr_q  <= (state_nx == ST_ERR) ? BUS_ASSERTED : BUS_RELEASED;
      doe_q   <= (rw_nx && ((state_nx == ST_REQ) || (state_nx == ST_ACK)))
                 ? BUS_ASSERTED : BUS_RELEASED;
      dinle_q <= (state_nx == ST_LATCH);
      req_q   <= (state_nx == ST_REQ) || (state_nx == ST_ACK);
    end
  end

  assign bus.nDTACK  = dtack_q;
  assign bus.nBERR   = berr_q;
  assign bus.nDoutOE = doe_q;
  assign bus.DinLE   = dinle_q;
  assign bus.REGREQ  = req_q;
  assign bus.REGRW   = rw_q;
  assign bus.REGLDS  = lds_q;
  assign bus.REGUDS  = uds_q;

endmodule

// File: doc/pds_target.md
# pds_target

PDS bus target (slave) port. Responds to 68000-style cycles that an external or on-board bus master drives onto the PDS bus: nAS, RnW, nLDS and nUDS. The block synchronizes the bus strobes into the C16M domain, decodes cycles aimed at this card, and runs a request/acknowledge handshake to the internal register port. It terminates each claimed cycle with nDTACK, or with nBERR if the register port does not acknowledge in time. It sits between the PDS pins/data-latch enables and the card's internal register file.

## Interface
Parameters:
- TIMEOUT, 64: C16M cycles allowed from cycle claim to REGACK before nBERR.
- TOW, 7: timeout counter width; must satisfy 2^TOW > TIMEOUT.

Ports (clock: single rising-edge domain C16M; reset: nRES, asynchronous, active-low):
- C16M  in  1  16 MHz system clock; all state updates on rising edge.
- nRES  in  1  asynchronous active-low reset.
- nAS  in  1  PDS address strobe, async to C16M.
- RnW  in  1  PDS read/not-write.
- nLDS  in  1  PDS lower data strobe, async.
- nUDS  in  1  PDS upper data strobe, async.
- SEL  in  1  address-decode hit for this card; valid while nAS low.
- nDTACK  out  1  data acknowledge to master; 1 = released.
- nBERR  out  1  bus error to master; 1 = released.
- nDoutOE  out  1  enables read-data drivers onto PDS data bus; active low.
- DinLE  out  1  write-data latch enable; active-high one-cycle pulse.
- REGREQ  out  1  request to internal register port.
- REGRW  out  1  1 = read, 0 = write; stable while REGREQ high.
- REGLDS  out  1  lower-byte select; stable while REGREQ high.
- REGUDS  out  1  upper-byte select; stable while REGREQ high.
- REGACK  in  1  single-cycle acknowledge from register port.

## Operation
- Reset values: nDTACK=1, nBERR=1, nDoutOE=1, DinLE=0, REGREQ=0, REGRW=1, REGLDS=0, REGUDS=0. The state machine goes to IDLE and the timeout counter clears. Reset asserted mid-cycle releases all bus outputs immediately, without waiting for a clock edge.
- Synchronizers: nAS, nLDS and nUDS each pass through 2 flops, producing ASs, LDSs and UDSs. RnW and SEL are sampled raw, on the edge where IDLE first sees ASs asserted.
- States: IDLE, DSWAIT, LATCH, REQ, ACK, ERR, HOLD.
  - IDLE
    - ASs low and SEL=1 on a read: latch REGRW=1 and REGLDS/REGUDS from LDSs/UDSs, go to REQ, drive nDoutOE=0.
    - ASs low and SEL=1 on a write: go to DSWAIT.
    - ASs low and SEL=0: go to HOLD; the cycle is ignored.
  - DSWAIT: when LDSs or UDSs is asserted, latch the byte selects, set REGRW=0 and go to LATCH.
  - LATCH: DinLE=1 for exactly this cycle, then go to REQ.
  - REQ: REGREQ=1 until REGACK is sampled high, then go to ACK with nDTACK=0.
  - ACK: hold nDTACK=0, plus nDoutOE=0 on reads, until ASs negates. Then release nDTACK and nDoutOE, drop REGREQ, and go to IDLE.
  - ERR: nBERR=0 and REGREQ=0 until ASs negates, then nBERR=1 and go to IDLE.
  - HOLD: wait for ASs to negate, then go to IDLE.
- Timeout: the counter clears in IDLE and increments each cycle in DSWAIT, LATCH and REQ. When count reaches TIMEOUT-1 without REGACK, go to ERR.
- REGACK in the same cycle as the timeout: ACK wins, nBERR is not asserted.
- Master abort: ASs negates while in DSWAIT, LATCH or REQ. Drop REGREQ and DinLE, release nDoutOE, and return to IDLE. No nDTACK or nBERR is generated. A late REGACK is ignored.
- REGACK is ignored in every state except REQ.
- nDTACK and nBERR are never asserted together.

## Timing
- Latency from nAS sampled low (edge 0):
  - Edge 1: ASs valid.
  - Edge 2: REQ entered, REGREQ=1.
  - Edge 3 at the earliest: nDTACK=0 with zero-wait REGACK.
- Writes: nDTACK falls 2 edges after LDSs/UDSs are first seen (LATCH, then REQ).
- Read data must be valid from REGACK until nDoutOE rises. nDoutOE is low for the whole REQ and ACK span.
- Release: nDTACK, nBERR and nDoutOE negate at most 3 C16M edges after nAS rises (≤190 ns).
- Back-to-back cycles: IDLE can claim a new nAS on the edge after release.

## Structure
- Shared package pds_pkg holds:
  - state enumeration (3-bit encoding);
  - default TIMEOUT constant;
  - polarity constants for the released/asserted bus levels.
- One sub-module, pds_sync: parameterized-width 2-flop synchronizer with asynchronous clear to the inactive level. It is instantiated once, 3 bits wide, for nAS, nLDS and nUDS.

## Test plan
- Word read, SEL=1, REGACK one cycle after REGREQ:
  - REGRW=1, REGLDS=REGUDS=1.
  - nDTACK=0 at edge 4 after nAS falls.
  - nDoutOE=0 from edge 2.
  - All outputs released within 3 edges of nAS rise.
- Byte write to the upper byte, with nUDS low 2 cycles after nAS:
  - DinLE high for exactly 1 cycle.
  - Then REGREQ with REGRW=0, REGUDS=1, REGLDS=0.
  - nDTACK low after REGACK; nDoutOE stays 1.
- REGACK tied low, TIMEOUT=64:
  - nBERR=0 exactly 64 cycles after the claim.
  - nDTACK stays 1.
  - nBERR released after nAS rises.
- REGACK coincident with the timeout cycle: nDTACK=0 and nBERR stays 1.
- SEL=0 cycle followed by a SEL=1 read: the first cycle gets no REGREQ, nDTACK or nDoutOE; the second completes normally.
- Aborts and reset:
  - nAS negated while in REQ: REGREQ drops and no acknowledge is returned.
  - nRES pulsed low while in ACK: nDTACK=1 immediately (asynchronously), state IDLE.
